// File: rtl/mont_exp_pkg.sv
// Shared RSA definitions: default widths, exponentiation FSM states, multiplier ops.
package rsa_defs;

    localparam int unsigned WIDTH_DEF = 512;
    localparam int unsigned ELEN_DEF  = 512;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MM_RST,
        MM_START,
        MM_WAIT,
        NEXT,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        TO_MONT,
        SQUARE,
        MULT,
        FROM_MONT
    } op_t;

    typedef enum logic [1:0] {
        MM_IDLE,
        MM_RUN,
        MM_FIX,
        MM_HOLD
    } mm_state_t;

endpackage

// File: rtl/mont_exp_if.sv
// Host-side launch/result bundle of the modular exponentiation engine.
interface mont_exp_if
    import rsa_defs::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned ELEN  = ELEN_DEF
);
    logic             start;
    logic [WIDTH-1:0] in_x;
    logic [ELEN-1:0]  in_e;
    logic [WIDTH-1:0] in_m;
    logic [WIDTH-1:0] in_r;
    logic [WIDTH-1:0] in_r2;
    logic [WIDTH-1:0] result;
    logic             done;

    modport master (output start, in_x, in_e, in_m, in_r, in_r2, input result, done);
    modport slave  (input start, in_x, in_e, in_m, in_r, in_r2, output result, done);
endinterface

// File: rtl/mont_exp_montgomery.sv
// Bit-serial radix-2 Montgomery multiplier: result = a*b*2^-WIDTH mod m, held until reset.
module montgomery
    import rsa_defs::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH+1:0] result,
    output logic             done
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    mm_state_t        state, state_n;
    logic [CW-1:0]    cnt;
    logic [WIDTH+1:0] acc, sum, sum_odd;
    logic             last;

    // acc stays below 2m, so acc + b + m fits in WIDTH+2 bits
    always_comb begin
        last    = (cnt == CW'(WIDTH - 1));
        sum     = acc + (a[cnt] ? {2'b00, b} : '0);
        sum_odd = sum[0] ? sum + {2'b00, m} : sum;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            MM_IDLE, MM_HOLD: if (start) state_n = MM_RUN;
            MM_RUN:           if (last) state_n = MM_FIX;
            MM_FIX:           state_n = MM_HOLD;
            default:          state_n = MM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) state <= MM_IDLE;
        else         state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            acc <= '0;
            cnt <= '0;
        end else begin
            unique case (state)
                MM_IDLE, MM_HOLD: begin
                    if (start) begin
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                MM_RUN: begin
                    acc <= sum_odd >> 1;
                    cnt <= cnt + CW'(1);
                end
                MM_FIX: if (acc >= {2'b00, m}) acc <= acc - {2'b00, m};
                default: ;
            endcase
        end
    end

    assign result = acc;
    assign done   = (state == MM_HOLD);
endmodule

// File: rtl/mont_exp.sv
// Modular exponentiation x^e mod m: left-to-right square-and-multiply in the Montgomery domain.
module mont_exp
    import rsa_defs::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned ELEN  = ELEN_DEF
) (
    input  logic       clk,
    input  logic       resetn,
    mont_exp_if.slave  bus
);
    localparam int unsigned IW = (ELEN > 1) ? $clog2(ELEN) : 1;

    state_t           state, state_n;
    op_t              op, op_n;
    logic             idx_step;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] a_reg, xt_reg, x_reg, m_reg, r_reg, r2_reg, result_reg;
    logic [ELEN-1:0]  e_reg;
    logic             done_reg;

    logic             mm_resetn, mm_rst_c, mm_start, mm_done;
    logic [WIDTH-1:0] mm_a, mm_b, mm_m;
    logic [WIDTH+1:0] mm_result;
    logic             unused_hi;

    assign unused_hi = ^mm_result[WIDTH+1:WIDTH];
    assign mm_rst_c  = (state == MM_RST);
    assign mm_resetn = resetn & ~mm_rst_c;
    assign mm_start  = (state == MM_START);
    assign mm_m      = m_reg;

    always_comb begin
        mm_a = a_reg;
        mm_b = a_reg;
        unique case (op)
            TO_MONT:   begin mm_a = x_reg; mm_b = r2_reg; end
            SQUARE:    mm_b = a_reg;
            MULT:      mm_b = xt_reg;
            FROM_MONT: mm_b = WIDTH'(1);
            default:   ;
        endcase
    end

    always_comb begin
        state_n  = state;
        op_n     = op;
        idx_step = 1'b0;
        unique case (state)
            IDLE, DONE: if (bus.start) state_n = LOAD;
            LOAD:       state_n = MM_RST;
            MM_RST:     state_n = MM_START;
            MM_START:   state_n = MM_WAIT;
            MM_WAIT:    if (mm_done) state_n = NEXT;
            NEXT: begin
                state_n = (op == FROM_MONT) ? DONE : MM_RST;
                // MULT closes bit i exactly like a SQUARE whose exponent bit is 0
                if (op == TO_MONT) begin
                    op_n = SQUARE;
                end else if (op == SQUARE && e_reg[idx]) begin
                    op_n = MULT;
                end else if (op != FROM_MONT) begin
                    if (idx != '0) begin
                        op_n     = SQUARE;
                        idx_step = 1'b1;
                    end else begin
                        op_n = FROM_MONT;
                    end
                end
            end
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            op         <= TO_MONT;
            idx        <= '0;
            a_reg      <= '0;
            xt_reg     <= '0;
            x_reg      <= '0;
            e_reg      <= '0;
            m_reg      <= '0;
            r_reg      <= '0;
            r2_reg     <= '0;
            result_reg <= '0;
            done_reg   <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        x_reg    <= bus.in_x;
                        e_reg    <= bus.in_e;
                        m_reg    <= bus.in_m;
                        r_reg    <= bus.in_r;
                        r2_reg   <= bus.in_r2;
                        done_reg <= 1'b0;
                    end
                end
                LOAD: begin
                    a_reg <= r_reg;
                    idx   <= IW'(ELEN - 1);
                    op    <= TO_MONT;
                end
                NEXT: begin
                    op <= op_n;
                    if (idx_step) idx <= idx - IW'(1);
                    if (op == TO_MONT) xt_reg <= mm_result[WIDTH-1:0];
                    else               a_reg  <= mm_result[WIDTH-1:0];
                    if (op == FROM_MONT) begin
                        result_reg <= mm_result[WIDTH-1:0];
                        done_reg   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.result = result_reg;
    assign bus.done   = done_reg;

    montgomery #(.WIDTH(WIDTH)) u_mm (
        .clk    (clk),
        .resetn (mm_resetn),
        .start  (mm_start),
        .a      (mm_a),
        .b      (mm_b),
        .m      (mm_m),
        .result (mm_result),
        .done   (mm_done)
    );
endmodule

// File: tb/tb_mont_exp.sv
// Directed-vector bench for mont_exp at a reduced 16-bit width with an 8-bit exponent.
module tb_mont_exp;
    localparam int unsigned W = 16;
    localparam int unsigned E = 8;

    typedef struct {
        logic [W-1:0] x;
        logic [E-1:0] e;
        logic [W-1:0] m;
        logic [W-1:0] r;
        logic [W-1:0] r2;
        logic [W-1:0] res;
        int unsigned  ncalls;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    int unsigned calls = 0;
    int unsigned snap;
    int          errors = 0;
    int          checks = 0;
    vec_t        vecs[12];

    mont_exp_if #(.WIDTH(W), .ELEN(E)) bus ();

    mont_exp #(.WIDTH(W), .ELEN(E)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (dut.mm_start) calls <= calls + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.in_x  = v.x;
        bus.in_e  = v.e;
        bus.in_m  = v.m;
        bus.in_r  = v.r;
        bus.in_r2 = v.r2;
    endtask

    task automatic scramble();
        bus.in_x  = W'($urandom);
        bus.in_e  = E'($urandom);
        bus.in_m  = W'($urandom);
        bus.in_r  = W'($urandom);
        bus.in_r2 = W'($urandom);
    endtask

    task automatic launch(input vec_t v);
        @(negedge clk);
        drive(v);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        scramble();
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 4000; i++) begin
            if (bus.done) break;
            @(negedge clk);
        end
        check({name, " done"}, {31'b0, bus.done}, 32'd1);
    endtask

    task automatic wait_calls(input int unsigned base, input int unsigned n);
        for (int i = 0; i < 1000; i++) begin
            if (calls - base >= n) break;
            @(negedge clk);
        end
        check("reach mm call", {31'b0, (calls - base >= n)}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int unsigned base;
        base = calls;
        launch(v);
        wait_done(name);
        check({name, " result"}, {16'b0, bus.result}, {16'b0, v.res});
        check({name, " mm calls"}, calls - base, v.ncalls);
    endtask

    initial begin
        vecs[0]  = '{x:16'd3,     e:8'd3,   m:16'd11,    r:16'd9,  r2:16'd4,   res:16'd5,     ncalls:12};
        vecs[1]  = '{x:16'd3,     e:8'd0,   m:16'd11,    r:16'd9,  r2:16'd4,   res:16'd1,     ncalls:10};
        vecs[2]  = '{x:16'd7,     e:8'd1,   m:16'd11,    r:16'd9,  r2:16'd4,   res:16'd7,     ncalls:11};
        vecs[3]  = '{x:16'd2,     e:8'd10,  m:16'd11,    r:16'd9,  r2:16'd4,   res:16'd1,     ncalls:12};
        vecs[4]  = '{x:16'd5,     e:8'd255, m:16'd13,    r:16'd3,  r2:16'd9,   res:16'd8,     ncalls:18};
        vecs[5]  = '{x:16'd2,     e:8'd16,  m:16'd65521, r:16'd15, r2:16'd225, res:16'd15,    ncalls:11};
        vecs[6]  = '{x:16'd65520, e:8'd255, m:16'd65521, r:16'd15, r2:16'd225, res:16'd65520, ncalls:18};
        vecs[7]  = '{x:16'd12345, e:8'd1,   m:16'd65535, r:16'd1,  r2:16'd1,   res:16'd12345, ncalls:11};
        vecs[8]  = '{x:16'd2,     e:8'd128, m:16'd3,     r:16'd1,  r2:16'd1,   res:16'd1,     ncalls:11};
        vecs[9]  = '{x:16'd10,    e:8'd3,   m:16'd101,   r:16'd88, r2:16'd68,  res:16'd91,    ncalls:12};
        vecs[10] = '{x:16'd0,     e:8'd0,   m:16'd7,     r:16'd2,  r2:16'd4,   res:16'd1,     ncalls:10};
        vecs[11] = '{x:16'd0,     e:8'd5,   m:16'd7,     r:16'd2,  r2:16'd4,   res:16'd0,     ncalls:12};

        bus.start = 1'b0;
        scramble();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        check("reset done", {31'b0, bus.done}, 32'd0);
        check("reset result", {16'b0, bus.result}, 32'd0);
        resetn = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // done and result hold in DONE
        repeat (10) @(negedge clk);
        check("hold done", {31'b0, bus.done}, 32'd1);
        check("hold result", {16'b0, bus.result}, {16'b0, vecs[11].res});

        // start in DONE: done drops on the cycle after acceptance
        snap = calls;
        launch(vecs[0]);
        check("done drop", {31'b0, bus.done}, 32'd0);
        wait_done("restart");
        check("restart result", {16'b0, bus.result}, 32'd5);
        check("restart calls", calls - snap, 32'd12);

        // start during MM_WAIT with other operands is ignored
        snap = calls;
        launch(vecs[0]);
        wait_calls(snap, 2);
        repeat (3) @(negedge clk);
        drive(vecs[2]);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        scramble();
        wait_done("ignored start");
        check("ignored start result", {16'b0, bus.result}, 32'd5);
        check("ignored start calls", calls - snap, 32'd12);

        // reset in the middle of MM_WAIT aborts
        snap = calls;
        launch(vecs[4]);
        wait_calls(snap, 3);
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        check("abort done", {31'b0, bus.done}, 32'd0);
        check("abort result", {16'b0, bus.result}, 32'd0);
        snap = calls;
        repeat (50) @(negedge clk);
        check("abort idle done", {31'b0, bus.done}, 32'd0);
        check("abort idle calls", calls - snap, 32'd0);
        run_vec(vecs[0], "after abort");

        // reset and start together: reset wins, nothing launches
        @(negedge clk);
        resetn = 1'b0;
        drive(vecs[2]);
        bus.start = 1'b1;
        @(negedge clk);
        resetn = 1'b1;
        bus.start = 1'b0;
        snap = calls;
        repeat (40) @(negedge clk);
        check("rst+start done", {31'b0, bus.done}, 32'd0);
        check("rst+start result", {16'b0, bus.result}, 32'd0);
        check("rst+start calls", calls - snap, 32'd0);
        run_vec(vecs[2], "after rst+start");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
